uart_io_led_sequencer: RTL and testbench

UART_IO_LED_SEQUENCER -- requirements
Module: uart_io_led_sequencer

---
 rtl/uart_io_led_sequencer_pkg.sv | 43 ++++
 rtl/uart_io_led_seq_timer.sv | 27 ++
 rtl/uart_io_led_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_uart_io_led_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_io_led_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, step ops,
// FSM states and LED PIO register offsets.
package uart_io_led_sequencer_pkg;

  localparam logic [3:0] ADDR_CTRL    = 4'd0;
  localparam logic [3:0] ADDR_STATUS  = 4'd1;
  localparam logic [3:0] ADDR_PERIOD  = 4'd2;
  localparam logic [3:0] ADDR_LENGTH  = 4'd3;
  localparam logic [3:0] ADDR_PATTERN = 4'd8;

  // Offsets inside the LED PIO slave
  localparam logic [2:0] PIO_DATA = 3'd0;
  localparam logic [2:0] PIO_SET  = 3'd4;
  localparam logic [2:0] PIO_CLR  = 3'd5;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLR   = 2'b10,
    OP_SKIP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    WAIT  = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
  } pattern_t;

  function automatic logic [2:0] op_target(input logic [1:0] op);
    case (op)
      OP_SET:  return PIO_SET;
      OP_CLR:  return PIO_CLR;
      default: return PIO_DATA;
    endcase
  endfunction

endpackage

// File: rtl/uart_io_led_seq_timer.sv
// Step-period down counter: loaded on WAIT entry, expire is high during the
// last cycle of the loaded period.
module uart_io_led_seq_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == W'(1));

endmodule

// File: rtl/uart_io_led_sequencer.sv
// Register-programmed LED pattern sequencer: steps through a pattern table and
// issues one write per step to an LED PIO slave, paced by a period timer.
module uart_io_led_sequencer
  import uart_io_led_sequencer_pkg::*;
#(
  parameter int PERIOD_W  = 24,
  parameter int NUM_STEPS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        busy,
  output state_e      fsm_state
);

  // Only table entries that fit below address 16 are reachable from the bus
  localparam int         NUM_MAPPED = (NUM_STEPS < 8) ? NUM_STEPS : 8;
  localparam logic [4:0] MAX_LEN    = 5'(NUM_STEPS);

  state_e              state, state_next;
  logic                ctrl_en, ctrl_oneshot, en_prev, done;
  logic [PERIOD_W-1:0] period, period_eff;
  logic [4:0]          length, len_eff;
  pattern_t            pattern [NUM_STEPS];
  pattern_t            pat_sel, cur;
  logic [3:0]          step, step_next;
  logic                wr_stb, start, last_step;
  logic                timer_load, expire, seq_done, load_cur;
  logic                unused_wdata;

  assign wr_stb       = s_chipselect & ~s_write_n;
  assign start        = ctrl_en & ~en_prev;
  assign busy         = (state != IDLE);
  assign fsm_state    = state;
  assign unused_wdata = ^s_writedata;

  always_comb begin
    len_eff = length;
    if (length == 5'd0) len_eff = 5'd1;
    else if (length > MAX_LEN) len_eff = MAX_LEN;
  end

  assign last_step  = ({1'b0, step} == (len_eff - 5'd1));
  assign period_eff = (period == '0) ? PERIOD_W'(1) : period;

  always_comb begin
    pat_sel = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (step == 4'(i)) pat_sel = pattern[i];
    end
  end

  // Software register file; hardware one-shot completion beats a same-cycle W1C
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      en_prev      <= 1'b0;
      done         <= 1'b0;
      period       <= PERIOD_W'(1);
      length       <= 5'd1;
      for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
    end else begin
      en_prev <= ctrl_en;
      if (wr_stb) begin
        case (s_address)
          ADDR_CTRL: begin
            ctrl_en      <= s_writedata[0];
            ctrl_oneshot <= s_writedata[1];
          end
          ADDR_PERIOD: period <= s_writedata[PERIOD_W-1:0];
          ADDR_LENGTH: length <= s_writedata[4:0];
          default: ;
        endcase
      end
      for (int i = 0; i < NUM_MAPPED; i++) begin
        if (wr_stb && (s_address == ADDR_PATTERN + 4'(i))) pattern[i] <= s_writedata[9:0];
      end
      if (seq_done) begin
        ctrl_en <= 1'b0;
        done    <= 1'b1;
      end else if (wr_stb && (s_address == ADDR_STATUS) && s_writedata[1]) begin
        done <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
      cur   <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
      if (load_cur) cur <= pat_sel;
    end
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    timer_load = 1'b0;
    seq_done   = 1'b0;
    load_cur   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          step_next  = '0;
        end
      end
      LOAD: begin
        if (!ctrl_en) begin
          state_next = IDLE;
        end else begin
          load_cur = 1'b1;
          if (pat_sel.op == OP_SKIP) begin
            state_next = WAIT;
            timer_load = 1'b1;
          end else begin
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        // An accepted write always finishes; EN only decides where to go next
        if (!m_waitrequest) begin
          if (ctrl_en) begin
            state_next = WAIT;
            timer_load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      WAIT: begin
        if (!ctrl_en) begin
          state_next = IDLE;
        end else if (expire) begin
          if (!last_step) begin
            step_next  = step + 4'd1;
            state_next = LOAD;
          end else if (ctrl_oneshot) begin
            seq_done   = 1'b1;
            state_next = IDLE;
          end else begin
            step_next  = '0;
            state_next = LOAD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  uart_io_led_seq_timer #(.W(PERIOD_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (period_eff),
    .expire     (expire)
  );

  always_comb begin
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = '0;
    m_writedata  = '0;
    if (state == WRITE) begin
      m_chipselect = 1'b1;
      m_write_n    = 1'b0;
      m_address    = op_target(cur.op);
      m_writedata  = {24'b0, cur.data};
    end
  end

  always_comb begin
    s_readdata = '0;
    case (s_address)
      ADDR_CTRL:   s_readdata = {30'b0, ctrl_oneshot, ctrl_en};
      ADDR_STATUS: s_readdata = {24'b0, step, 2'b0, done, busy};
      ADDR_PERIOD: s_readdata[PERIOD_W-1:0] = period;
      ADDR_LENGTH: s_readdata = {27'b0, length};
      default: begin
        for (int i = 0; i < NUM_MAPPED; i++) begin
          if (s_address == ADDR_PATTERN + 4'(i)) s_readdata = {22'b0, pattern[i]};
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_io_led_sequencer.sv
// Bench for the LED sequencer: a step-level reference model predicts every
// master write (target, data, cycle); a monitor compares accepted writes.
module tb_uart_io_led_sequencer;
  import uart_io_led_sequencer_pkg::*;

  localparam int PERIOD_W  = 24;
  localparam int NUM_STEPS = 8;
  localparam int EW        = 67;
  localparam logic [31:0] NO_TIME = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  s_address;
  logic        s_chipselect, s_write_n;
  logic [31:0] s_writedata, s_readdata;
  logic [2:0]  m_address;
  logic        m_chipselect, m_write_n, m_waitrequest;
  logic [31:0] m_writedata;
  logic        busy;
  state_e      fsm_state;

  uart_io_led_sequencer #(.PERIOD_W(PERIOD_W), .NUM_STEPS(NUM_STEPS)) dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];   // {cycle, pio offset, data}
  int n_cmp = 0;
  int n_fail = 0;
  int stall_cycles = 0;
  int wr_mode = 0;           // 0 none, 1 random, 2 four-cycle stall, 3 hold high
  int stall_cnt = 0;

  // reference model of the programmed registers
  logic [9:0] m_pat [NUM_STEPS];
  int m_period = 1;
  int m_length = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int eff_len();
    if (m_length == 0) return 1;
    if (m_length > NUM_STEPS) return NUM_STEPS;
    return m_length;
  endfunction

  function automatic int eff_period();
    return (m_period == 0) ? 1 : m_period;
  endfunction

  function automatic logic [2:0] pio_offset(input logic [1:0] op);
    if (op == 2'd1) return 3'd4;
    if (op == 2'd2) return 3'd5;
    return 3'd0;
  endfunction

  // Each step costs one LOAD cycle, one WRITE cycle unless skipped, then PERIOD
  // cycles of WAIT. k is the clock edge on which EN becomes 1.
  task automatic push_run(input int k, input int visits, input bit timed, output int t_end);
    int t = k + 1;
    int s;
    for (int v = 0; v < visits; v++) begin
      s = v % eff_len();
      if (m_pat[s][9:8] != 2'b11) begin
        exp_q.push_back({timed ? 32'(t + 1) : NO_TIME, pio_offset(m_pat[s][9:8]), 24'b0, m_pat[s][7:0]});
        t += 1;
      end
      t += 1 + eff_period();
    end
    t_end = t;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_write(input logic [3:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
    @(posedge clk); #1;
    s_address = '0; s_writedata = '0; s_chipselect = 1'b0; s_write_n = 1'b1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    drive_write(a, d);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    s_address = a; s_chipselect = 1'b1; s_write_n = 1'b1;
    #1 d = s_readdata;
    s_address = '0; s_chipselect = 1'b0;
  endtask

  task automatic set_pattern(input int i, input logic [1:0] op, input logic [7:0] data);
    bus_write(4'(8 + i), {22'b0, op, data});
    m_pat[i] = {op, data};
  endtask

  task automatic set_period(input int p);
    bus_write(ADDR_PERIOD, 32'(p));
    m_period = p;
  endtask

  task automatic set_length(input int l);
    bus_write(ADDR_LENGTH, 32'(l));
    m_length = l;
  endtask

  task automatic start_run(input bit oneshot, input int visits, input bit timed, output int t_end);
    @(posedge clk); #1;
    push_run(cyc + 1, visits, timed, t_end);
    drive_write(ADDR_CTRL, {30'b0, oneshot, 1'b1});
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    repeat (2) @(posedge clk);
    #1;
    while (busy && n < budget) begin @(posedge clk); #1; n++; end
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_q_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic check_done_and_clear(input string name);
    logic [31:0] rd;
    check({name, "_q_empty"}, exp_q.size(), 0);
    bus_read(ADDR_STATUS, rd);
    check({name, "_done_busy"}, rd[1:0], 2'b10);
    bus_read(ADDR_CTRL, rd);
    check({name, "_ctrl"}, rd[1:0], 2'b10);
    bus_write(ADDR_STATUS, 32'h2);
    bus_read(ADDR_STATUS, rd);
    check({name, "_w1c"}, rd[1], 1'b0);
  endtask

  // ---------------- waitrequest generator ----------------
  initial begin
    m_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (wr_mode)
        1: m_waitrequest = ($urandom_range(0, 2) == 0);
        2: begin
          if (m_chipselect && stall_cnt < 4) begin
            m_waitrequest = 1'b1;
            stall_cnt++;
          end else begin
            m_waitrequest = 1'b0;
            if (!m_chipselect) stall_cnt = 0;
          end
        end
        3: m_waitrequest = 1'b1;
        default: m_waitrequest = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic [EW-1:0] mon_e;
  logic          prev_stall = 1'b0;
  logic [34:0]   prev_req;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (m_chipselect) begin
        check("write_n_low", m_write_n, 1'b0);
        if (prev_stall) check("stall_stable", {m_address, m_writedata}, prev_req);
        if (m_waitrequest) stall_cycles++;
        else if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %0h, required no write (cycle %0d)",
                   m_address, m_writedata, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", m_address, mon_e[34:32]);
          check("write_data", m_writedata, mon_e[31:0]);
          if (mon_e[66:35] != NO_TIME) check("write_cycle", cyc, mon_e[66:35]);
        end
      end else begin
        check("idle_bus", {m_write_n, m_address, m_writedata}, {1'b1, 3'b0, 32'b0});
      end
      prev_stall = m_chipselect & m_waitrequest;
      prev_req   = {m_address, m_writedata};
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion within 50000 cycles");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_values(input string name);
    logic [31:0] rd;
    check({name, "_outputs"}, {busy, m_chipselect, m_write_n, m_address, m_writedata},
          {1'b0, 1'b0, 1'b1, 3'b0, 32'b0});
    bus_read(ADDR_CTRL, rd);      check({name, "_ctrl"}, rd, 32'h0);
    bus_read(ADDR_STATUS, rd);    check({name, "_status"}, rd, 32'h0);
    bus_read(ADDR_PERIOD, rd);    check({name, "_period"}, rd, 32'h1);
    bus_read(ADDR_LENGTH, rd);    check({name, "_length"}, rd, 32'h1);
    bus_read(4'd8, rd);           check({name, "_pattern0"}, rd, 32'h0);
    bus_read(4'd9, rd);           check({name, "_pattern1"}, rd, 32'h0);
    bus_read(4'd5, rd);           check({name, "_unmapped"}, rd, 32'h0);
  endtask

  task automatic reset_model();
    for (int i = 0; i < NUM_STEPS; i++) m_pat[i] = '0;
    m_period = 1;
    m_length = 1;
  endtask

  initial begin
    logic [31:0] rd;
    int t_end;
    int n;
    reset = 1'b1;
    s_address = '0; s_chipselect = 1'b0; s_write_n = 1'b1; s_writedata = '0;
    reset_model();
    #1;
    check_reset_values("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // unmapped write ignored
    bus_write(4'd6, 32'hFFFF_FFFF);
    bus_read(4'd6, rd);
    check("unmapped_write", rd, 32'h0);

    // two-step continuous sequence wraps back to step 0
    set_pattern(0, 2'b00, 8'hA5);
    set_pattern(1, 2'b00, 8'h5A);
    set_period(3);
    set_length(2);
    start_run(1'b0, 3, 1'b1, t_end);
    wait_q_empty("wrap", 60);
    drive_write(ADDR_CTRL, 32'h0);
    wait_idle("wrap", 20);
    bus_read(ADDR_STATUS, rd);
    check("wrap_no_done", rd[1], 1'b0);

    // one-shot with set / clear / skip steps
    set_pattern(0, 2'b01, 8'h0F);
    set_pattern(1, 2'b10, 8'h03);
    set_pattern(2, 2'b11, 8'($urandom_range(0, 255)));
    set_length(3);
    set_period($urandom_range(1, 3));
    start_run(1'b1, 3, 1'b1, t_end);
    wait_idle("oneshot", 100);
    check_done_and_clear("oneshot");

    // four-cycle waitrequest stall: one write, stable request
    wr_mode = 2;
    set_pattern(0, 2'b00, 8'($urandom_range(0, 255)));
    set_length(1);
    stall_cycles = 0;
    start_run(1'b1, 1, 1'b0, t_end);
    wait_idle("stall", 100);
    check("stall_cycles", stall_cycles, 4);
    check_done_and_clear("stall");
    wr_mode = 0;

    // EN cleared while a write is stalled: write still completes, no DONE
    wr_mode = 3;
    set_pattern(0, 2'b01, 8'($urandom_range(0, 255)));
    set_period(2);
    start_run(1'b0, 1, 1'b0, t_end);
    n = 0;
    while (!m_chipselect && n < 20) begin @(posedge clk); #1; n++; end
    check("abort_reached_write", m_chipselect, 1'b1);
    bus_write(ADDR_CTRL, 32'h0);
    repeat (2) @(posedge clk);
    #1 wr_mode = 0;
    wait_idle("abort", 20);
    check("abort_q_empty", exp_q.size(), 0);
    bus_read(ADDR_STATUS, rd);
    check("abort_no_done", rd[1], 1'b0);

    // PERIOD=0 / LENGTH=0 act as 1; W1C on the completion edge loses to the set
    set_period(0);
    set_length(0);
    set_pattern(0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    start_run(1'b1, 1, 1'b1, t_end);
    n = 0;
    while (cyc < t_end - 1 && n < 50) begin @(posedge clk); #1; n++; end
    drive_write(ADDR_STATUS, 32'h2);
    bus_read(ADDR_STATUS, rd);
    check("w1c_race_done", rd[1:0], 2'b10);
    check_done_and_clear("zero_cfg");

    // randomized one-shot runs
    for (int r = 0; r < 16; r++) begin
      wr_mode = $urandom_range(0, 1);
      for (int i = 0; i < NUM_STEPS; i++)
        set_pattern(i, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      set_period($urandom_range(0, 3));
      set_length($urandom_range(0, 12));
      start_run(1'b1, eff_len(), (wr_mode == 0), t_end);
      wait_idle("rand", 600);
      wr_mode = 0;
      check_done_and_clear("rand");
    end

    // reset in the middle of WAIT
    set_pattern(0, 2'b00, 8'h3C);
    set_period(20);
    set_length(2);
    start_run(1'b0, 1, 1'b1, t_end);
    wait_q_empty("midwait", 20);
    repeat (3) @(posedge clk);
    #1;
    check("midwait_busy", busy, 1'b1);
    reset = 1'b1;
    reset_model();
    exp_q.delete();
    #1;
    check_reset_values("midwait_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("post_reset_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
